// File: rtl/conv_mem_pkg.sv
// Shared types for the convolution sample-memory readers.
// State encoding and the RAM read latency these readers are built around.
package conv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

    localparam int READER_RAM_LATENCY = 1;

endpackage

// File: rtl/conv_reader_fifo.sv
// Small synchronous FIFO holding {last, data} beats between the RAM and the stream port.
// A push and a pop in the same cycle are legal even when full; the head is read combinationally.
module conv_reader_fifo
    import conv_mem_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop = pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/conv_mem_stream_reader.sv
// Burst reader for a 1-cycle-latency sample RAM, presenting words as a valid/ready stream with last.
// Build option CONV_READER_STRIDE_EN adds stride_i (address step latched on start); default step is 1.
module conv_mem_stream_reader
    import conv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
`ifdef CONV_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
    output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output reader_state_t         state_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2) begin : g_depth_check
        $error("conv_mem_stream_reader: FIFO_DEPTH must be >= 2");
    end

    reader_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [DATA_WIDTH:0]   w_head;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_issue;

`ifdef CONV_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_stride;
    assign w_step = r_stride;
`else
    assign w_step = ADDR_WIDTH'(1);
`endif

    assign w_pop = !w_empty && ready_i;

    // Count the slot an in-flight read will occupy and credit a beat leaving this cycle.
    always_comb begin
        w_issue = 1'b0;
        if (r_state == ISSUE && r_remaining != '0)
            w_issue = (int'(w_count) + int'(r_inflight)) < (FIFO_DEPTH + int'(w_pop));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
`ifdef CONV_READER_STRIDE_EN
            r_stride        <= ADDR_WIDTH'(1);
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == (ADDR_WIDTH+1)'(1));
            r_done          <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_addr      <= base_addr_i;
                        r_remaining <= length_i;
`ifdef CONV_READER_STRIDE_EN
                        r_stride    <= stride_i;
`endif
                        if (length_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + w_step;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (ADDR_WIDTH+1)'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head[DATA_WIDTH]) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (!(r_inflight && w_full && !w_pop))
            else $error("conv_mem_stream_reader: output FIFO overflow");
    end

    conv_reader_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH),
        .CW   (CW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (r_inflight),
        .wdata({r_inflight_last, ram_read_data_i}),
        .pop  (w_pop),
        .rdata(w_head),
        .count(w_count),
        .full (w_full),
        .empty(w_empty)
    );

    assign ram_read_addr_o = r_addr;
    assign valid_o         = !w_empty;
    assign data_o          = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign last_o          = !w_empty && w_head[DATA_WIDTH];
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign state_o         = r_state;

endmodule

// File: tb/tb_conv_mem_stream_reader.sv
// Directed bench: reader paired with a 1-cycle-read RAM preloaded addr k -> 8'hA0+k.
// Expected beats are queued at burst start and popped by a negedge stream monitor.
module tb_conv_mem_stream_reader;
    import conv_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [AW-1:0] stride_in;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready;
    logic          last_o;
    logic          busy_o;
    logic          done_o;
    reader_state_t state_o;

    logic [DW-1:0] ram_mem [1 << AW];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int stride   = 1;

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic          stall_prev;
    logic [DW:0]   held;

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= ram_mem[ram_addr];

    conv_mem_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .base_addr_i    (base_addr),
        .length_i       (length),
`ifdef CONV_READER_STRIDE_EN
        .stride_i       (stride_in),
`endif
        .ram_read_addr_o(ram_addr),
        .ram_read_data_i(ram_rdata),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .state_o        (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: scoreboard pops, hold-under-stall, done pulses, issued address trace.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {valid_o, last_o, data_o}, {1'b1, held});
            if (valid_o && ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", {last_o, data_o}, 32'h1ff);
                else check("beat", {last_o, data_o}, exp_q.pop_front());
            end
            stall_prev = valid_o && !ready;
            held       = {last_o, data_o};
            if (done_o) done_cnt++;
            if (busy_o && (addr_log.size() == 0 || addr_log[$] != ram_addr))
                addr_log.push_back(ram_addr);
        end
    end

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic do_burst(input int base, input int len, input int mode, input bit restart);
        int cycle;
        int first_valid;
        int done_before;
        logic [DW-1:0] d;
        for (int k = 0; k < len; k++) begin
            d = 8'hA0 + 8'((base + k * stride) % 16);
            exp_q.push_back({(k == len - 1), d});
        end
        addr_log.delete();
        done_before = done_cnt;
        first_valid = -1;
        base_addr   = AW'(base);
        length      = (AW+1)'(len);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycle = 0;
        while (!done_o && cycle < 200) begin
            if (valid_o && first_valid < 0) first_valid = cycle;
            ready = (mode == 1) ? ((cycle % 4 == 0) || (cycle % 4 == 3)) : 1'b1;
            if (restart && cycle == 4) begin
                start     = 1'b1;
                base_addr = AW'(9);
                length    = (AW+1)'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycle++;
        end
        start = 1'b0;
        check("burst_timeout", (cycle < 200), 1);
        if (mode == 0 && len > 0) begin
            check("first_valid_latency", first_valid, 2);
            check("done_cycle", cycle, len + 2);
        end
        if (len == 0) begin
            check("len0_done_window", (cycle <= 2), 1);
            check("len0_no_valid", first_valid, -1);
        end
        ready = 1'b1;
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        check("busy_after", busy_o, 0);
        check("done_one_cycle", done_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt - done_before, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_last"}, last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_state"}, state_o, IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) ram_mem[k] = 8'hA0 + 8'(k);
        rst       = 1'b1;
        start     = 1'b0;
        ready     = 1'b1;
        base_addr = '0;
        length    = '0;
        stride_in = AW'(1);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic, wrap, backpressure, edge lengths, start while busy.
        do_burst(3, 5, 0, 1'b0);
        do_burst(14, 4, 0, 1'b0);
        check("wrap_addr_count", (addr_log.size() >= 4), 1);
        check("wrap_addr0", addr_log[0], 14);
        check("wrap_addr1", addr_log[1], 15);
        check("wrap_addr2", addr_log[2], 0);
        check("wrap_addr3", addr_log[3], 1);
        do_burst(4, 8, 1, 1'b0);
        do_burst(0, 0, 0, 1'b0);
        do_burst(0, 16, 0, 1'b0);
        do_burst(2, 6, 0, 1'b1);

        // Reset mid-burst after two beats, with the third beat stalled.
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'hA6});
        base_addr = AW'(5);
        length    = (AW+1)'(8);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ready = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_beats", exp_q.size(), 0);
        check("pre_reset_valid", valid_o, 1);
        check("pre_reset_busy", busy_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midreset");
        rst   = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        do_burst(0, 2, 0, 1'b0);

`ifdef CONV_READER_STRIDE_EN
        stride    = 3;
        stride_in = AW'(3);
        do_burst(1, 4, 0, 1'b0);
        stride    = 1;
        stride_in = AW'(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
